// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch buffer.
//   DEF_ADDR_W / DEF_INSTR_W : default fetch address and instruction widths
//   fetch_entry_t            : one buffered instruction with its fetch address
//   fetch_tag_t              : one in-flight memory read (valid + address)
package fetch_pkg;
  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_INSTR_W = 32;

  typedef struct packed {
    logic [DEF_INSTR_W-1:0] instr;
    logic [DEF_ADDR_W-1:0]  pc;
  } fetch_entry_t;

  typedef struct packed {
    logic                  valid;
    logic [DEF_ADDR_W-1:0] addr;
  } fetch_tag_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small register-based FIFO holding returned instructions until decode takes them.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   push, push_data       : write one entry (caller guarantees room or a same-cycle pop)
//   pop                   : remove the head entry; ignored when empty
//   flush                 : empty the FIFO at this edge; a push in the same cycle is dropped
//   head                  : current head entry (valid when !empty)
//   count, empty, full    : occupancy status
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int W     = DEF_INSTR_W + DEF_ADDR_W,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [W-1:0]     entry_q [DEPTH];
  logic [W-1:0]     entry_d [DEPTH];
  logic             push_eff, pop_eff;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;
  assign head     = entry_q[rd_ptr_q];
  assign push_eff = push & ~flush;
  assign pop_eff  = pop & ~empty & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap on their own.
      if (push_eff) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_eff)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(push_eff) - CNT_W'(pop_eff);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is reset so the head reads as zero straight out of reset.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_comb begin
      entry_d[gi] = entry_q[gi];
      if (push_eff && (wr_ptr_q == PTR_W'(gi))) entry_d[gi] = push_data;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) entry_q[gi] <= '0;
      else       entry_q[gi] <= entry_d[gi];
    end
  end
endmodule

// File: rtl/fetch_buffer.sv
// Fetch buffer between the program counter and decode.
// Accepts PC fetch requests while credits remain, issues reads to a fixed-latency
// instruction memory, tracks them in a MEM_LAT-deep tag pipeline and buffers the
// returned words in order for decode.
// Ports:
//   clk, reset                    : clock, asynchronous active-high reset
//   pc_addr, pc_valid, pc_stall   : request from the PC and backpressure to it
//   flush                         : branch redirect, discards buffered and in-flight fetches
//   mem_rd, mem_addr, mem_rdata   : instruction memory read port (data MEM_LAT cycles after mem_rd)
//   instr, instr_pc, instr_valid,
//   instr_ready                   : head instruction handshake to decode
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int DEPTH   = 4,
  parameter int MEM_LAT = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_addr,
  input  logic               pc_valid,
  output logic               pc_stall,
  input  logic               flush,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready
);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int OCC_W = $clog2(DEPTH+MEM_LAT+1);

  logic              tag_valid_q [MEM_LAT];
  logic              tag_valid_d [MEM_LAT];
  logic [ADDR_W-1:0] tag_addr_q  [MEM_LAT];
  logic [ADDR_W-1:0] tag_addr_d  [MEM_LAT];

  logic [OCC_W-1:0]  occupancy;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty, fifo_full, fifo_push, fifo_pop;
  logic              req_live, credit_ok, accept;

  // Every in-flight read already owns a FIFO slot, so counting them here is
  // what keeps the FIFO from ever overflowing.
  always_comb begin
    occupancy = OCC_W'(fifo_count);
    for (int i = 0; i < MEM_LAT; i++) occupancy = occupancy + OCC_W'(tag_valid_q[i]);
  end

  // Requests are ignored entirely during flush and reset: no read, no stall.
  assign req_live  = pc_valid & ~flush & ~reset;
  assign credit_ok = (occupancy < OCC_W'(DEPTH));
  assign accept    = req_live & credit_ok;
  assign pc_stall  = req_live & ~credit_ok;
  assign mem_rd    = accept;
  assign mem_addr  = pc_addr & ~ADDR_W'(3);

  for (genvar gi = 0; gi < MEM_LAT; gi++) begin : g_tag
    always_comb begin
      if (gi == 0) begin
        tag_valid_d[gi] = accept;
        tag_addr_d[gi]  = mem_addr;
      end else begin
        tag_valid_d[gi] = tag_valid_q[gi-1] & ~flush;
        tag_addr_d[gi]  = tag_addr_q[gi-1];
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        tag_valid_q[gi] <= 1'b0;
        tag_addr_q[gi]  <= '0;
      end else begin
        tag_valid_q[gi] <= tag_valid_d[gi];
        tag_addr_q[gi]  <= tag_addr_d[gi];
      end
    end
  end

  // The last tag stage lines up with the cycle mem_rdata is valid.
  assign fifo_push = tag_valid_q[MEM_LAT-1] & ~flush;
  assign fifo_pop  = instr_ready;

  fetch_fifo #(
    .W     (INSTR_W + ADDR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({mem_rdata, tag_addr_q[MEM_LAT-1]}),
    .pop       (fifo_pop),
    .flush     (flush),
    .head      ({instr, instr_pc}),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign instr_valid = ~fifo_empty;

  // A push into a full FIFO without a same-cycle pop means the credit count is broken.
  always_ff @(posedge clk) begin
    if (!reset) assert (!(fifo_push && fifo_full && !(instr_valid && instr_ready)));
  end
endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer with a fixed-latency memory model that returns
// addr ^ 0xA5A5_0000 exactly MEM_LAT cycles after each read (0xDEADBEEF otherwise).
module tb_fetch_buffer;
  import fetch_pkg::*;

  localparam int MEM_LAT = 2;
  localparam logic [31:0] SALT = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc_addr;
  logic        pc_valid;
  logic        pc_stall;
  logic        flush;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_buffer #(.ADDR_W(16), .INSTR_W(32), .DEPTH(4), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .reset(reset), .pc_addr(pc_addr), .pc_valid(pc_valid), .pc_stall(pc_stall),
    .flush(flush), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  // Memory model: delay line of read strobes and addresses.
  logic        mv [MEM_LAT];
  logic [15:0] ma [MEM_LAT];
  always @(posedge clk) begin
    mv[0] <= mem_rd;
    ma[0] <= mem_addr;
    for (int i = 1; i < MEM_LAT; i++) begin
      mv[i] <= mv[i-1];
      ma[i] <= ma[i-1];
    end
  end
  assign mem_rdata = mv[MEM_LAT-1] ? ({16'h0, ma[MEM_LAT-1]} ^ SALT) : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fetch_entry_t exp_e;
    int           rd_cnt;
    int           pops;
    logic [15:0]  pc;

    // ---------------- reset state (pc_valid held high to prove mem_rd stays 0)
    reset = 1'b1; flush = 1'b0; pc_valid = 1'b1; pc_addr = 16'h0040; instr_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_instr_pc", instr_pc, 0);
    check("rst_pc_stall", pc_stall, 0);
    check("rst_mem_rd", mem_rd, 0);
    tick();
    reset = 1'b0; pc_valid = 1'b0;
    tick();

    // ---------------- basic stream 0x0000/0x0004/0x0008, latency 3
    for (int c = 0; c < 7; c++) begin
      pc_valid = (c < 3); pc_addr = 16'(c * 4); instr_ready = 1'b1;
      @(negedge clk);
      if (c < 3) begin
        check("t1_mem_rd", mem_rd, 1);
        check("t1_mem_addr", mem_addr, 64'(c * 4));
      end
      check("t1_instr_valid", instr_valid, 64'(c >= 3 && c <= 5));
      if (c >= 3 && c <= 5) begin
        exp_e.pc    = 16'((c - 3) * 4);
        exp_e.instr = {16'h0, exp_e.pc} ^ SALT;
        check("t1_entry", {instr, instr_pc}, exp_e);
      end
      tick();
    end

    // ---------------- backpressure: 4 credits, then stall, then steady drain
    pc = 16'h0100; rd_cnt = 0; pops = 0;
    for (int c = 0; c < 14; c++) begin
      pc_valid = 1'b1; pc_addr = pc; instr_ready = (c >= 8);
      @(negedge clk);
      if (mem_rd) begin
        check("t2_mem_addr", mem_addr, pc);
        rd_cnt++;
        pc = pc + 16'd4;
      end
      if (c == 7) begin
        check("t2_rd_pulses", rd_cnt, 4);
        check("t2_stall_full", pc_stall, 1);
        check("t2_head_held", instr_pc, 16'h0100);
      end
      if (c == 8) check("t2_stall_pop_cycle", pc_stall, 1);
      if (c == 9) check("t2_stall_release", pc_stall, 0);
      if (instr_valid && instr_ready) begin
        check("t2_pop_pc", instr_pc, 16'h0100 + 16'(4 * pops));
        check("t2_pop_instr", instr, {16'h0, 16'h0100 + 16'(4 * pops)} ^ SALT);
        pops++;
      end
      tick();
    end
    pc_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (instr_valid && instr_ready) begin
        check("t2_drain_pc", instr_pc, 16'h0100 + 16'(4 * pops));
        pops++;
      end
      tick();
    end
    check("t2_total_reads", rd_cnt, 9);
    check("t2_total_pops", pops, 9);

    // ---------------- flush with two reads in flight
    pc_valid = 1'b1; pc_addr = 16'h0010; tick();
    pc_addr = 16'h0014; tick();
    flush = 1'b1; pc_addr = 16'h0200;
    @(negedge clk);
    check("t3_flush_no_rd", mem_rd, 0);
    check("t3_flush_no_stall", pc_stall, 0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("t3_redirect_rd", mem_rd, 1);
    check("t3_redirect_addr", mem_addr, 16'h0200);
    check("t3_valid_after_flush", instr_valid, 0);
    tick();
    pc_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("t3_no_stale", instr_valid, 0);
      tick();
    end
    @(negedge clk);
    check("t3_redirect_valid", instr_valid, 1);
    check("t3_redirect_pc", instr_pc, 16'h0200);
    check("t3_redirect_instr", instr, 32'hA5A5_0200);
    tick();
    @(negedge clk);
    check("t3_only_one", instr_valid, 0);
    tick();

    // ---------------- push and pop in the same cycle, order preserved
    instr_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      pc_valid = 1'b1; pc_addr = 16'h00A0 + 16'(4 * c);
      tick();
    end
    pc_addr = 16'h00B0;
    @(negedge clk);
    check("t4_stall", pc_stall, 1);
    check("t4_no_rd", mem_rd, 0);
    tick();
    pc_valid = 1'b0; instr_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t4_valid", instr_valid, 1);
      check("t4_order", instr_pc, 16'h00A0 + 16'(4 * c));
      tick();
    end
    @(negedge clk);
    check("t4_empty", instr_valid, 0);
    tick();

    // ---------------- unaligned address
    pc_valid = 1'b1; pc_addr = 16'h0006;
    @(negedge clk);
    check("t5_mem_addr", mem_addr, 16'h0004);
    tick();
    pc_valid = 1'b0;
    tick(); tick();
    @(negedge clk);
    check("t5_valid", instr_valid, 1);
    check("t5_instr_pc", instr_pc, 16'h0004);
    check("t5_instr", instr, 32'hA5A5_0004);
    tick();

    // ---------------- async reset mid-stream, stale return afterwards
    instr_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      pc_valid = 1'b1; pc_addr = 16'h0300 + 16'(4 * c);
      tick();
    end
    pc_addr = 16'h030C;
    @(negedge clk);
    check("t6_pre_valid", instr_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_valid", instr_valid, 0);
    check("t6_rst_instr", instr, 0);
    check("t6_rst_pc", instr_pc, 0);
    check("t6_rst_mem_rd", mem_rd, 0);
    check("t6_rst_stall", pc_stall, 0);
    tick();
    reset = 1'b0; pc_valid = 1'b0; instr_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t6_stale_valid", instr_valid, 0);
      check("t6_stale_instr", instr, 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
